// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
//   Write-back scheduler placed in front of the register file's two write ports.
//   E-stage and M-stage results are each buffered in their own FIFO and one entry
//   per port is issued every cycle. When both heads target the same register, the
//   M result wins and the E result is dropped. A per-register count of in-flight
//   writes drives the decode stall.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   e_valid/e_dst/e_data  E result offer; e_ready = E FIFO not full
//   m_valid/m_dst/m_data  M result offer; m_ready = M FIFO not full
//   rA, rB                decode read addresses checked against pending writes
//   dstE/valE, dstM/valM  register file write ports (dst 4'hF = idle)
//   stall                 rA or rB has a write still in flight
//   coll_cnt              saturating count of same-register collisions
module regfile_wb_sched #(
    parameter int DEPTH = 4,
    parameter int NREGS = 8,
    parameter int CNTW  = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            e_valid,
    input  logic [3:0]      e_dst,
    input  logic [31:0]     e_data,
    output logic            e_ready,
    input  logic            m_valid,
    input  logic [3:0]      m_dst,
    input  logic [31:0]     m_data,
    output logic            m_ready,
    input  logic [3:0]      rA,
    input  logic [3:0]      rB,
    output logic [3:0]      dstE,
    output logic [31:0]     valE,
    output logic [3:0]      dstM,
    output logic [31:0]     valM,
    output logic            stall,
    output logic [CNTW-1:0] coll_cnt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int SBW = $clog2(2 * DEPTH + 2) + 1;
    localparam int RW  = $clog2(NREGS);
    localparam logic [3:0] NREG_LIM = 4'(NREGS);
    localparam logic [3:0] IDLE     = 4'hF;

    // FIFO storage and bookkeeping
    logic [3:0]  eDstMem  [DEPTH];
    logic [31:0] eDataMem [DEPTH];
    logic [3:0]  mDstMem  [DEPTH];
    logic [31:0] mDataMem [DEPTH];
    logic [AW-1:0] eWr, eRd, mWr, mRd;
    logic [CW-1:0] eCount, mCount;

    logic [SBW-1:0] pending     [NREGS];
    logic [SBW-1:0] pendingNext [NREGS];

    logic eFull, mFull, eEmpty, mEmpty;
    logic ePush, mPush, ePop, mPop;
    logic collide, issueE;
    logic [3:0]  eHeadDst, mHeadDst;
    logic [31:0] eHeadData, mHeadData;

    assign eFull  = (eCount == CW'(DEPTH));
    assign mFull  = (mCount == CW'(DEPTH));
    assign eEmpty = (eCount == '0);
    assign mEmpty = (mCount == '0);

    // Readiness reflects fullness only; a same-cycle pop never frees a slot early.
    assign e_ready = !eFull;
    assign m_ready = !mFull;

    // Out-of-range destinations complete the handshake but are never stored.
    assign ePush = e_valid && !eFull && (e_dst < NREG_LIM);
    assign mPush = m_valid && !mFull && (m_dst < NREG_LIM);

    assign eHeadDst  = eDstMem[eRd];
    assign eHeadData = eDataMem[eRd];
    assign mHeadDst  = mDstMem[mRd];
    assign mHeadData = mDataMem[mRd];

    // Both heads are consumed every cycle they exist; on a collision E is dropped.
    assign ePop    = !eEmpty;
    assign mPop    = !mEmpty;
    assign collide = ePop && mPop && (eHeadDst == mHeadDst);
    assign issueE  = ePop && !collide;

    // NOTE: FIFO storage has no reset; only pointers and counts define what is valid,
    // so the arrays map onto plain RAM without a reset network.
    always_ff @(posedge clock) begin
        if (ePush) begin
            eDstMem[eWr]  <= e_dst;
            eDataMem[eWr] <= e_data;
        end
        if (mPush) begin
            mDstMem[mWr]  <= m_dst;
            mDataMem[mWr] <= m_data;
        end
    end

    // NOTE: all state uses non-blocking assignment so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            eWr      <= '0;
            eRd      <= '0;
            mWr      <= '0;
            mRd      <= '0;
            eCount   <= '0;
            mCount   <= '0;
            dstE     <= IDLE;
            valE     <= '0;
            dstM     <= IDLE;
            valM     <= '0;
            coll_cnt <= '0;
        end else begin
            if (ePush) eWr <= eWr + 1'b1;
            if (mPush) mWr <= mWr + 1'b1;
            if (ePop)  eRd <= eRd + 1'b1;
            if (mPop)  mRd <= mRd + 1'b1;
            eCount <= eCount + CW'(ePush) - CW'(ePop);
            mCount <= mCount + CW'(mPush) - CW'(mPop);

            dstE <= issueE ? eHeadDst  : IDLE;
            valE <= issueE ? eHeadData : '0;
            dstM <= mPop   ? mHeadDst  : IDLE;
            valM <= mPop   ? mHeadData : '0;

            if (collide && (coll_cnt != '1)) coll_cnt <= coll_cnt + CNTW'(1);
        end
    end

    // Pending writes per register: +1 per accepted push, -1 when an issued write
    // retires (the cycle after it is presented) or when an E entry is dropped.
    // NOTE: every element is assigned on every pass, so no latch can be inferred.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            pendingNext[r] = pending[r]
                + SBW'(ePush && (e_dst == 4'(r)))
                + SBW'(mPush && (m_dst == 4'(r)))
                - SBW'(dstE == 4'(r))
                - SBW'(dstM == 4'(r))
                - SBW'(collide && (eHeadDst == 4'(r)));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) pending[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) pending[r] <= pendingNext[r];
        end
    end

    assign stall = ((rA < NREG_LIM) && (pending[rA[RW-1:0]] != '0)) ||
                   ((rB < NREG_LIM) && (pending[rB[RW-1:0]] != '0));

endmodule
